// File: rtl/nmr_bstrm_sram_loader.sv
// nmr_bstrm_sram_loader
// ---------------------------------------------------------------------------
// Writer side of the NMR bitstream command SRAM. Host words arrive over a
// valid/ready stream and are packed four at a time into one 128-bit command
// word. Each command word is written to consecutive SRAM addresses starting
// at LOAD_BASE, where the bitstream sequencer later reads it.
//
// Packing, in arrival order within a group of four host words:
//   w0 -> [31:0]   control (flags [15:0], loop count [31:16])
//   w1 -> [63:32]  post-pulse delay
//   w2 -> [95:64]  pulse width
//   w3 -> [127:96] initial delay
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   LOAD_START                one-cycle pulse, begins a session when idle
//   LOAD_BASE, LOAD_NWORDS    first address / command word count, sampled on LOAD_START
//   DIN, DIN_VALID, DIN_READY host word stream
//   LOAD_BUSY, LOAD_DONE      session in progress / one-cycle end pulse
//   ERR_OVF                   sticky, requested range runs past the top of the RAM
//   ERR_VERIFY                sticky, readback mismatch (verify build only, else 0)
//   SRAM_*                    command RAM write port (plus read data for verify)
//
// Build option:
//   NMR_BSTRM_LOADER_VERIFY_EN  when defined, each written word is read back
//                               after SRAM_RD_LAT cycles and compared.
//
// The internal `state` register is the FSM state for bound checkers.
// ---------------------------------------------------------------------------
module nmr_bstrm_sram_loader #(
    parameter int SRAM_ADDR_WIDTH   = 8,
    parameter int SRAM_DAT_WIDTH    = 128,
    parameter int SRAM_BYTEEN_WIDTH = 16,
    parameter int DIN_WIDTH         = 32,
    parameter int SRAM_RD_LAT       = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         LOAD_START,
    input  logic [SRAM_ADDR_WIDTH-1:0]   LOAD_BASE,
    input  logic [SRAM_ADDR_WIDTH:0]     LOAD_NWORDS,
    input  logic [DIN_WIDTH-1:0]         DIN,
    input  logic                         DIN_VALID,
    output logic                         DIN_READY,
    output logic                         LOAD_BUSY,
    output logic                         LOAD_DONE,
    output logic                         ERR_OVF,
    output logic                         ERR_VERIFY,
    output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
    output logic                         SRAM_CS,
    output logic                         SRAM_CLKEN,
    output logic                         SRAM_WR,
    output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
    input  logic [SRAM_DAT_WIDTH-1:0]    SRAM_RD_DAT,
    output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3
`ifdef NMR_BSTRM_LOADER_VERIFY_EN
        ,
        S_VERIFY  = 3'd4,
        S_VWAIT   = 3'd5
`endif
    } state_t;

    // One past the highest RAM address; a session may end exactly here.
    localparam logic [SRAM_ADDR_WIDTH+1:0] ADDR_SPAN = {2'b01, {SRAM_ADDR_WIDTH{1'b0}}};

    state_t                     state;
    logic [SRAM_ADDR_WIDTH-1:0] cur_addr;
    logic [SRAM_ADDR_WIDTH:0]   nwords;
    logic [SRAM_ADDR_WIDTH:0]   written;
    logic [1:0]                 idx;
    logic [DIN_WIDTH-1:0]       slot [0:2];

    // Range check on the raw request: base + count may equal the span, never exceed it.
    logic [SRAM_ADDR_WIDTH+1:0] end_addr;
    logic                       start_ovf;
    assign end_addr  = {2'b00, LOAD_BASE} + {1'b0, LOAD_NWORDS};
    assign start_ovf = (end_addr > ADDR_SPAN);

`ifdef NMR_BSTRM_LOADER_VERIFY_EN
    localparam int VCW = (SRAM_RD_LAT > 1) ? $clog2(SRAM_RD_LAT) : 1;
    logic [VCW-1:0] vcnt;
`else
    localparam int unused_rd_lat = SRAM_RD_LAT;
    logic unused_rd;
    assign unused_rd  = ^SRAM_RD_DAT;
    assign ERR_VERIFY = 1'b0;
`endif

    // Handshake: a host word transfers on a rising edge where DIN_VALID and
    // DIN_READY are both 1. DIN_READY is a registered flag that is high
    // exactly while the FSM is in COLLECT; DIN is ignored at all other times.
    //
    // All outputs are registered on the edge that enters the state they
    // belong to. LOAD_DONE is raised on the edge that leaves the final
    // state of a session, so it is seen in the first IDLE cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            cur_addr    <= '0;
            nwords      <= '0;
            written     <= '0;
            idx         <= '0;
            slot[0]     <= '0;
            slot[1]     <= '0;
            slot[2]     <= '0;
            DIN_READY   <= 1'b0;
            LOAD_BUSY   <= 1'b0;
            LOAD_DONE   <= 1'b0;
            ERR_OVF     <= 1'b0;
            SRAM_ADDR   <= '0;
            SRAM_CS     <= 1'b0;
            SRAM_CLKEN  <= 1'b0;
            SRAM_WR     <= 1'b0;
            SRAM_WR_DAT <= '0;
            SRAM_BYTEEN <= '0;
`ifdef NMR_BSTRM_LOADER_VERIFY_EN
            ERR_VERIFY  <= 1'b0;
            vcnt        <= '0;
`endif
        end else begin
            LOAD_DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (LOAD_START) begin
                        cur_addr  <= LOAD_BASE;
                        nwords    <= LOAD_NWORDS;
                        written   <= '0;
                        idx       <= '0;
                        LOAD_BUSY <= 1'b1;
                        ERR_OVF   <= start_ovf;
`ifdef NMR_BSTRM_LOADER_VERIFY_EN
                        ERR_VERIFY <= 1'b0;
`endif
                        // An out-of-range request writes nothing at all.
                        if (start_ovf || (LOAD_NWORDS == '0)) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_COLLECT;
                            DIN_READY <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (DIN_VALID) begin
                        if (idx == 2'd3) begin
                            // Fourth word goes straight onto the write bus.
                            state       <= S_WRITE;
                            DIN_READY   <= 1'b0;
                            SRAM_CS     <= 1'b1;
                            SRAM_CLKEN  <= 1'b1;
                            SRAM_WR     <= 1'b1;
                            SRAM_BYTEEN <= '1;
                            SRAM_ADDR   <= cur_addr;
                            SRAM_WR_DAT <= {DIN, slot[2], slot[1], slot[0]};
                        end else begin
                            slot[idx] <= DIN;
                            idx       <= idx + 2'd1;
                        end
                    end
                end

                S_WRITE: begin
                    SRAM_WR     <= 1'b0;
                    SRAM_BYTEEN <= '0;
                    cur_addr    <= cur_addr + 1'b1;
                    written     <= written + 1'b1;
                    idx         <= '0;
`ifdef NMR_BSTRM_LOADER_VERIFY_EN
                    // CS/CLKEN stay high: next cycle is the readback strobe
                    // at the same SRAM_ADDR.
                    state <= S_VERIFY;
`else
                    SRAM_CS    <= 1'b0;
                    SRAM_CLKEN <= 1'b0;
                    if ((written + 1'b1) == nwords) begin
                        state     <= S_IDLE;
                        LOAD_BUSY <= 1'b0;
                        LOAD_DONE <= 1'b1;
                    end else begin
                        state     <= S_COLLECT;
                        DIN_READY <= 1'b1;
                    end
`endif
                end

`ifdef NMR_BSTRM_LOADER_VERIFY_EN
                S_VERIFY: begin
                    SRAM_CS    <= 1'b0;
                    SRAM_CLKEN <= 1'b0;
                    vcnt       <= '0;
                    state      <= S_VWAIT;
                end

                // Read data is valid SRAM_RD_LAT cycles after the strobe cycle.
                S_VWAIT: begin
                    if (vcnt == VCW'(SRAM_RD_LAT - 1)) begin
                        if (SRAM_RD_DAT != SRAM_WR_DAT) begin
                            ERR_VERIFY <= 1'b1;
                        end
                        if (written == nwords) begin
                            state     <= S_IDLE;
                            LOAD_BUSY <= 1'b0;
                            LOAD_DONE <= 1'b1;
                        end else begin
                            state     <= S_COLLECT;
                            DIN_READY <= 1'b1;
                        end
                    end else begin
                        vcnt <= vcnt + 1'b1;
                    end
                end
`endif

                S_DONE: begin
                    state     <= S_IDLE;
                    LOAD_BUSY <= 1'b0;
                    LOAD_DONE <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nmr_bstrm_sram_loader.sv
// Testbench for nmr_bstrm_sram_loader.
// Expected SRAM writes ({addr, data}) are queued as stimulus is driven and
// popped by a write monitor; each scenario task also checks its own timing
// and status outputs inline.
module tb_nmr_bstrm_sram_loader;

    localparam int AW = 8;
    localparam int DW = 128;
    localparam int BW = 16;
    localparam int IW = 32;
    localparam int RL = 2;
`ifdef NMR_BSTRM_LOADER_VERIFY_EN
    localparam int POST = 2 + RL;   // cycles from write strobe to LOAD_DONE
`else
    localparam int POST = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW-1:0] load_base;
    logic [AW:0]   load_nwords;
    logic [IW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          load_busy;
    logic          load_done;
    logic          err_ovf;
    logic          err_verify;
    logic [AW-1:0] sram_addr;
    logic          sram_cs;
    logic          sram_clken;
    logic          sram_wr;
    logic [DW-1:0] sram_wr_dat;
    logic [DW-1:0] sram_rd_dat;
    logic [BW-1:0] sram_byteen;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_exp;

    always #5 clk = ~clk;

    nmr_bstrm_sram_loader #(
        .SRAM_ADDR_WIDTH(AW), .SRAM_DAT_WIDTH(DW), .SRAM_BYTEEN_WIDTH(BW),
        .DIN_WIDTH(IW), .SRAM_RD_LAT(RL)
    ) dut (
        .CLK(clk), .RST(rst), .LOAD_START(load_start), .LOAD_BASE(load_base),
        .LOAD_NWORDS(load_nwords), .DIN(din), .DIN_VALID(din_valid),
        .DIN_READY(din_ready), .LOAD_BUSY(load_busy), .LOAD_DONE(load_done),
        .ERR_OVF(err_ovf), .ERR_VERIFY(err_verify), .SRAM_ADDR(sram_addr),
        .SRAM_CS(sram_cs), .SRAM_CLKEN(sram_clken), .SRAM_WR(sram_wr),
        .SRAM_WR_DAT(sram_wr_dat), .SRAM_RD_DAT(sram_rd_dat), .SRAM_BYTEEN(sram_byteen)
    );

    // SRAM model: synchronous write, RL-cycle read pipeline; address 1
    // reads back with bit 1 flipped to provoke a verify mismatch.
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:RL-1];

    always @(posedge clk) begin
        if (sram_cs && sram_clken && sram_wr)
            mem[sram_addr] <= sram_wr_dat;
        if (sram_cs && sram_clken && !sram_wr)
            rd_pipe[0] <= mem[sram_addr] ^ ((sram_addr == AW'(1)) ? DW'(2) : DW'(0));
        for (int i = 1; i < RL; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rd_dat = rd_pipe[RL-1];

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (sram_wr === 1'b1) begin
            n_wr++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%0d data=%h", sram_addr, sram_wr_dat);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({sram_cs, sram_clken, sram_byteen, sram_addr, sram_wr_dat} !==
                    {2'b11, 16'hFFFF, mon_exp}) begin
                    n_fail++;
                    $display("FAIL sram_write got cs=%b clken=%b be=%h addr=%0d data=%h exp addr=%0d data=%h",
                             sram_cs, sram_clken, sram_byteen, sram_addr, sram_wr_dat,
                             mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; load_start = 1'b0; din_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic start(input logic [AW-1:0] base, input logic [AW:0] n);
        load_base = base; load_nwords = n; load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [IW-1:0] w, input bit gap);
        bit rdy;
        int waited;
        if (gap) begin
            din_valid = 1'b0; din = $urandom;
            tick();
        end
        din = w; din_valid = 1'b1; waited = 0;
        do begin
            rdy = din_ready;
            tick();
            waited++;
        end while (!rdy && waited < 50);
        din_valid = 1'b0; din = $urandom;
        if (!rdy) begin
            n_tests++; n_fail++;
            $display("FAIL din_accept_timeout word=%h", w);
        end
    endtask

    // Sends one command word; returns in the write cycle.
    task automatic send_cmd(input logic [AW-1:0] addr, input logic [IW-1:0] w0, input logic [IW-1:0] w1,
                            input logic [IW-1:0] w2, input logic [IW-1:0] w3,
                            input logic [DW-1:0] exp_dat, input bit gap);
        exp_q.push_back({addr, exp_dat});
        send_word(w0, gap); send_word(w1, gap); send_word(w2, gap); send_word(w3, gap);
        n_tests++;
        if (sram_wr !== 1'b1) begin
            n_fail++; $display("FAIL write_latency sram_wr=%b exp=1", sram_wr);
        end
        n_tests++;
        if (din_ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_in_write din_ready=%b exp=0", din_ready);
        end
    endtask

    task automatic wait_done(input int max);
        int c = 0;
        while (load_done !== 1'b1 && c < max) begin
            tick(); c++;
        end
        n_tests++;
        if (load_done !== 1'b1) begin
            n_fail++; $display("FAIL done_timeout load_done=%b exp=1", load_done);
        end
    endtask

    task automatic check_q_empty(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL %s pending_writes=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_dut();
        n_tests++;
        if ({din_ready, load_busy, load_done, err_ovf, err_verify, sram_cs, sram_clken,
             sram_wr, sram_addr, sram_wr_dat, sram_byteen} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs rdy=%b busy=%b done=%b ovf=%b ver=%b cs=%b wr=%b addr=%h be=%h exp all 0",
                     din_ready, load_busy, load_done, err_ovf, err_verify, sram_cs, sram_wr, sram_addr, sram_byteen);
        end
    endtask

    task automatic test_single_write();
        start(8'd0, 9'd1);
        send_cmd(8'd0, 32'h0003_0000, 32'd5, 32'd5, 32'd5,
                 128'h00000005_00000005_00000005_00030000, 1'b0);
        repeat (POST) tick();
        n_tests++;
        if ({load_done, load_busy} !== 2'b10) begin
            n_fail++; $display("FAIL single_done done=%b busy=%b exp done=1 busy=0", load_done, load_busy);
        end
        tick();
        n_tests++;
        if (load_done !== 1'b0) begin
            n_fail++; $display("FAIL done_pulse_width load_done=%b exp=0", load_done);
        end
        check_q_empty("single_write");
    endtask

    task automatic test_valid_toggle();
        logic [IW-1:0] w [4];
        start(8'd4, 9'd3);
        n_tests++;
        if ({load_busy, din_ready} !== 2'b11) begin
            n_fail++; $display("FAIL start_state busy=%b rdy=%b exp 1 1", load_busy, din_ready);
        end
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        send_cmd(8'd4, w[0], w[1], w[2], w[3], {w[3], w[2], w[1], w[0]}, 1'b1);
        // A second LOAD_START mid-session must not retarget the load.
        load_base = 8'd100; load_nwords = 9'd1; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_cmd(8'd5, 32'h0003_0001, 32'd7, 32'd21, 32'd15,
                 128'h0000000F_00000015_00000007_00030001, 1'b1);
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        send_cmd(8'd6, w[0], w[1], w[2], w[3], {w[3], w[2], w[1], w[0]}, 1'b1);
        repeat (POST) tick();
        n_tests++;
        if ({load_done, load_busy, err_ovf} !== 3'b100) begin
            n_fail++; $display("FAIL toggle_done done=%b busy=%b ovf=%b exp 1 0 0", load_done, load_busy, err_ovf);
        end
        check_q_empty("valid_toggle");
    endtask

    task automatic test_overflow();
        int wr0;
        wr0 = n_wr;
        start(8'd254, 9'd3);
        n_tests++;
        if ({err_ovf, din_ready} !== 2'b10) begin
            n_fail++; $display("FAIL ovf_flag ovf=%b rdy=%b exp 1 0", err_ovf, din_ready);
        end
        wait_done(4);
        tick(); tick();
        n_tests++;
        if ({err_ovf, load_done, load_busy} !== 3'b100) begin
            n_fail++; $display("FAIL ovf_sticky ovf=%b done=%b busy=%b exp 1 0 0", err_ovf, load_done, load_busy);
        end
        n_tests++;
        if (n_wr != wr0) begin
            n_fail++; $display("FAIL ovf_no_write writes=%0d exp=%0d", n_wr, wr0);
        end
        // Exactly reaching the top of the RAM is legal and clears the flag.
        start(8'd253, 9'd3);
        n_tests++;
        if ({err_ovf, din_ready} !== 2'b01) begin
            n_fail++; $display("FAIL top_fit ovf=%b rdy=%b exp 0 1", err_ovf, din_ready);
        end
        for (int k = 0; k < 3; k++) begin
            logic [IW-1:0] a, b, c, d;
            a = $urandom; b = $urandom; c = $urandom; d = $urandom;
            send_cmd(AW'(253 + k), a, b, c, d, {d, c, b, a}, 1'b0);
        end
        wait_done(POST + 2);
        check_q_empty("top_fit");
    endtask

    task automatic test_zero_words();
        int wr0;
        wr0 = n_wr;
        start(8'd9, 9'd0);
        n_tests++;
        if ({load_busy, load_done, sram_cs} !== 3'b100) begin
            n_fail++; $display("FAIL zero_busy busy=%b done=%b cs=%b exp 1 0 0", load_busy, load_done, sram_cs);
        end
        // Ignored: block is still busy.
        load_base = 8'd0; load_nwords = 9'd1; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n_tests++;
        if ({load_done, load_busy} !== 2'b10) begin
            n_fail++; $display("FAIL zero_done done=%b busy=%b exp 1 0", load_done, load_busy);
        end
        tick();
        n_tests++;
        if ({load_busy, din_ready, load_done, sram_cs} !== 4'b0000) begin
            n_fail++; $display("FAIL busy_start_ignored busy=%b rdy=%b done=%b cs=%b exp 0 0 0 0",
                               load_busy, din_ready, load_done, sram_cs);
        end
        n_tests++;
        if (n_wr != wr0) begin
            n_fail++; $display("FAIL zero_no_write writes=%0d exp=%0d", n_wr, wr0);
        end
    endtask

    task automatic test_mid_reset();
        logic [IW-1:0] a, b, c, d;
        start(8'd0, 9'd1);
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({din_ready, load_busy, load_done, err_ovf, err_verify, sram_cs, sram_clken,
             sram_wr, sram_addr, sram_wr_dat, sram_byteen} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs rdy=%b busy=%b cs=%b wr=%b exp all 0",
                               din_ready, load_busy, sram_cs, sram_wr);
        end
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        start(8'd8, 9'd1);
        send_cmd(8'd8, a, b, c, d, {d, c, b, a}, 1'b0);
        wait_done(POST + 2);
        check_q_empty("mid_reset");
    endtask

`ifdef NMR_BSTRM_LOADER_VERIFY_EN
    task automatic test_verify();
        logic [IW-1:0] w [12];
        for (int i = 0; i < 12; i++) w[i] = $urandom;
        start(8'd0, 9'd3);
        send_cmd(8'd0, w[0], w[1], w[2], w[3], {w[3], w[2], w[1], w[0]}, 1'b0);
        send_cmd(8'd1, w[4], w[5], w[6], w[7], {w[7], w[6], w[5], w[4]}, 1'b0);
        n_tests++;
        if (err_verify !== 1'b0) begin
            n_fail++; $display("FAIL verify_good_word err_verify=%b exp=0", err_verify);
        end
        send_cmd(8'd2, w[8], w[9], w[10], w[11], {w[11], w[10], w[9], w[8]}, 1'b0);
        n_tests++;
        if (err_verify !== 1'b1) begin
            n_fail++; $display("FAIL verify_mismatch err_verify=%b exp=1", err_verify);
        end
        wait_done(POST + 2);
        check_q_empty("verify");
        start(8'd5, 9'd1);
        n_tests++;
        if (err_verify !== 1'b0) begin
            n_fail++; $display("FAIL verify_clear err_verify=%b exp=0", err_verify);
        end
        send_cmd(8'd5, w[0], w[1], w[2], w[3], {w[3], w[2], w[1], w[0]}, 1'b0);
        wait_done(POST + 2);
        check_q_empty("verify_clean");
    endtask
`endif

    initial begin
        rst = 1'b1; load_start = 1'b0; load_base = '0; load_nwords = '0;
        din = '0; din_valid = 1'b0;
        test_reset();
        test_single_write();
        test_valid_toggle();
        test_overflow();
        test_zero_words();
        test_mid_reset();
`ifdef NMR_BSTRM_LOADER_VERIFY_EN
        test_verify();
`endif
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
